// File: rtl/led_target_generator_if.sv
`default_nettype none
// ============================================================================
// Module   : led_target_generator_if
// Brief    : Game-state, tick and hit inputs plus LED/score/round/result
//            outputs of the LED target generator, bundled as one interface.
// Revision : 1.0 - initial release
// ============================================================================
interface led_target_generator_if;
   logic [2:0] i_State;
   logic       i_Sec1Tick;
   logic       i_Comparison;
   logic [7:0] o_Led;
   logic [7:0] o_Score;
   logic [7:0] o_Round;
   logic       o_Clear;
   logic       o_Fail;

   // master = game controller / comparison side, slave = the generator
   modport master (
      output i_State, i_Sec1Tick, i_Comparison,
      input  o_Led, o_Score, o_Round, o_Clear, o_Fail
   );
   modport slave (
      input  i_State, i_Sec1Tick, i_Comparison,
      output o_Led, o_Score, o_Round, o_Clear, o_Fail
   );
endinterface
`default_nettype wire

// File: rtl/led_target_generator.sv
`default_nettype none
// ============================================================================
// Module   : led_target_generator
// Brief    : One-hot LED target pattern, score/round keeping and one-cycle
//            clear/fail requests for a bomb-game round.
// Revision : 1.0 - initial release
// ============================================================================
module led_target_generator #(
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   parameter logic [7:0]  TARGET_HITS = 8'd10,
   parameter logic [7:0]  MAX_ROUNDS  = 8'd20
) (
   input  wire logic              i_Clk,
   input  wire logic              i_Rst,
   led_target_generator_if.slave  bus
);
   localparam logic [2:0] c_ST_IDLE  = 3'b000;
   localparam logic [2:0] c_ST_START = 3'b001;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_fsm;
   logic [15:0] r_lfsr;
   logic [2:0]  r_prev_state;
   logic        r_hit_latched;
   logic [7:0]  r_led;
   logic [7:0]  r_score;
   logic [7:0]  r_round;
   logic        r_clear;
   logic        r_fail;

   logic        w_fb;
   logic [7:0]  w_cand_raw;
   logic [7:0]  w_cand;
   logic        w_entry;
   logic        w_hit;
   logic [7:0]  w_score_inc;

   assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   assign w_cand_raw  = 8'd1 << r_lfsr[2:0];
   // Rotating on a collision guarantees the next target differs from the current one
   assign w_cand      = (w_cand_raw == r_led) ? {w_cand_raw[6:0], w_cand_raw[7]} : w_cand_raw;
   assign w_entry     = (bus.i_State == c_ST_START) && (r_prev_state != c_ST_START);
   assign w_hit       = bus.i_Comparison && !r_hit_latched && (r_score < TARGET_HITS);
   assign w_score_inc = r_score + 8'd1;

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         r_fsm         <= S_IDLE;
         r_lfsr        <= LFSR_SEED;
         r_prev_state  <= c_ST_IDLE;
         r_hit_latched <= 1'b0;
         r_led         <= 8'd0;
         r_score       <= 8'd0;
         r_round       <= 8'd0;
         r_clear       <= 1'b0;
         r_fail        <= 1'b0;
      end else begin
         r_lfsr       <= {r_lfsr[14:0], w_fb};
         r_prev_state <= bus.i_State;
         r_clear      <= 1'b0;
         r_fail       <= 1'b0;
         case (r_fsm)
            S_IDLE: begin
               r_led <= 8'd0;
               if (w_entry) begin
                  r_led         <= w_cand;
                  r_score       <= 8'd0;
                  r_round       <= 8'd1;
                  r_hit_latched <= 1'b0;
                  r_fsm         <= S_PLAY;
               end
            end
            S_PLAY: begin
               if (bus.i_State != c_ST_START) begin
                  r_led <= 8'd0;
                  r_fsm <= S_IDLE;
               end else begin
                  if (w_hit) begin
                     r_score       <= w_score_inc;
                     r_hit_latched <= 1'b1;
                  end
                  // A winning hit takes precedence over a round-ending tick
                  if (w_hit && (w_score_inc == TARGET_HITS)) begin
                     r_clear <= 1'b1;
                     r_led   <= 8'd0;
                     r_fsm   <= S_DONE;
                  end else if (bus.i_Sec1Tick) begin
                     if (r_round == MAX_ROUNDS) begin
                        r_fail <= 1'b1;
                        r_led  <= 8'd0;
                        r_fsm  <= S_DONE;
                     end else begin
                        r_round       <= r_round + 8'd1;
                        r_led         <= w_cand;
                        r_hit_latched <= 1'b0;
                     end
                  end
               end
            end
            S_DONE: begin
               r_led <= 8'd0;
               if (bus.i_State == c_ST_IDLE) begin
                  r_fsm <= S_IDLE;
               end
            end
            default: begin
               r_led <= 8'd0;
               r_fsm <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.o_Led   = r_led;
   assign bus.o_Score = r_score;
   assign bus.o_Round = r_round;
   assign bus.o_Clear = r_clear;
   assign bus.o_Fail  = r_fail;
endmodule
`default_nettype wire

// File: tb/tb_led_target_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_target_generator
// Brief    : Scoreboard bench for led_target_generator game scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_target_generator;
   localparam logic [15:0] c_SEED = 16'hACE1;

   typedef struct packed {
      logic [7:0] led;
      logic [7:0] score;
      logic [7:0] round;
      logic       clr;
      logic       fail;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] m_lfsr;
   logic [7:0]  last_led = 8'd0;
   logic [7:0]  first_led = 8'd0;
   logic [7:0]  old_led;
   int          n_vec = 0;
   int          n_err = 0;
   exp_t        sb[$];

   led_target_generator_if bus();

   led_target_generator dut (
      .i_Clk (clk),
      .i_Rst (rst_n),
      .bus   (bus.slave)
   );

   always #10 clk = ~clk;

   // Reference pattern source, reset and clocked alongside the DUT
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= c_SEED;
      else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   function automatic logic [7:0] cand(input logic [15:0] l, input logic [7:0] prev);
      logic [7:0] r;
      r = 8'd1 << l[2:0];
      if (r == prev) r = {r[6:0], r[7]};
      return r;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // led_mode: 0 = expect dark, 1 = expect a freshly loaded target, 2 = expect target held
   task automatic step(input logic [2:0] st, input logic tk, input logic cm, input int led_mode,
                       input logic [7:0] es, input logic [7:0] er, input logic ec, input logic ef);
      exp_t e;
      bus.i_State      = st;
      bus.i_Sec1Tick   = tk;
      bus.i_Comparison = cm;
      case (led_mode)
         0:       e.led = 8'd0;
         1:       e.led = cand(m_lfsr, last_led);
         default: e.led = last_led;
      endcase
      last_led = e.led;
      e.score = es;
      e.round = er;
      e.clr   = ec;
      e.fail  = ef;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      check("led",   bus.o_Led,   e.led);
      check("score", bus.o_Score, e.score);
      check("round", bus.o_Round, e.round);
      check("clear", {7'd0, bus.o_Clear}, {7'd0, e.clr});
      check("fail",  {7'd0, bus.o_Fail},  {7'd0, e.fail});
   endtask

   task automatic do_reset();
      @(negedge clk);
      #5 rst_n = 1'b0;
      #1;
      check("rst_led",   bus.o_Led,   8'd0);
      check("rst_score", bus.o_Score, 8'd0);
      check("rst_round", bus.o_Round, 8'd0);
      check("rst_clear", {7'd0, bus.o_Clear}, 8'd0);
      check("rst_fail",  {7'd0, bus.o_Fail},  8'd0);
      last_led = 8'd0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time budget exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_State      = 3'b000;
      bus.i_Sec1Tick   = 1'b0;
      bus.i_Comparison = 1'b0;
      do_reset();
      step(3'b000, 0, 0, 0, 8'd0, 8'd0, 0, 0);

      // Game entry and single-count hit
      step(3'b001, 0, 0, 1, 8'd0, 8'd1, 0, 0);
      first_led = last_led;
      check("onehot", 8'($countones(bus.o_Led)), 8'd1);
      for (int i = 0; i < 5; i++) step(3'b001, 0, 1, 2, 8'd1, 8'd1, 0, 0);
      old_led = last_led;
      step(3'b001, 1, 0, 1, 8'd1, 8'd2, 0, 0);
      check("led_diff", {7'd0, bus.o_Led != old_led}, 8'd1);

      // Win after ten hits
      for (int r = 2; r <= 9; r++) begin
         step(3'b001, 0, 1, 2, 8'(r), 8'(r), 0, 0);
         step(3'b001, 1, 0, 1, 8'(r), 8'(r + 1), 0, 0);
      end
      step(3'b001, 0, 1, 0, 8'd10, 8'd10, 1, 0);
      step(3'b001, 0, 0, 0, 8'd10, 8'd10, 0, 0);
      step(3'b000, 0, 0, 0, 8'd10, 8'd10, 0, 0);
      step(3'b001, 0, 0, 1, 8'd0, 8'd1, 0, 0);

      // Fail after twenty empty rounds
      for (int r = 1; r <= 19; r++) step(3'b001, 1, 0, 1, 8'd0, 8'(r + 1), 0, 0);
      step(3'b001, 1, 0, 0, 8'd0, 8'd20, 0, 1);
      step(3'b001, 0, 0, 0, 8'd0, 8'd20, 0, 0);
      step(3'b000, 0, 0, 0, 8'd0, 8'd20, 0, 0);

      // Winning hit on the final tick: clear must beat fail
      step(3'b001, 0, 0, 1, 8'd0, 8'd1, 0, 0);
      for (int r = 1; r <= 19; r++) begin
         if (r <= 9) step(3'b001, 0, 1, 2, 8'(r), 8'(r), 0, 0);
         step(3'b001, 1, 0, 1, 8'((r <= 9) ? r : 9), 8'(r + 1), 0, 0);
      end
      step(3'b001, 1, 1, 0, 8'd10, 8'd20, 1, 0);
      step(3'b001, 0, 0, 0, 8'd10, 8'd20, 0, 0);
      step(3'b000, 0, 0, 0, 8'd10, 8'd20, 0, 0);

      // Abort to idle mid-game, then reset mid-game at round 7
      step(3'b001, 0, 0, 1, 8'd0, 8'd1, 0, 0);
      step(3'b000, 0, 0, 0, 8'd0, 8'd1, 0, 0);
      step(3'b001, 0, 0, 1, 8'd0, 8'd1, 0, 0);
      for (int r = 1; r <= 6; r++) step(3'b001, 1, 0, 1, 8'd0, 8'(r + 1), 0, 0);
      bus.i_State = 3'b000;
      bus.i_Sec1Tick = 1'b0;
      do_reset();
      step(3'b000, 0, 0, 0, 8'd0, 8'd0, 0, 0);
      step(3'b001, 0, 0, 1, 8'd0, 8'd1, 0, 0);
      check("restart_led", bus.o_Led, first_led);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
